// File: rtl/vga_fb_scanout.sv
// Framebuffer scan-out for a 640x480 VGA timing source: linear read addresses,
// pixel capture, and sync/blank delayed so colour and sync leave together.
module vga_fb_scanout #(
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int ADDR_BITS    = 20,
  parameter int DATA_BITS    = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 visible,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [9:0]           column,
  input  logic [9:0]           row,
  output logic                 fb_rd_en,
  output logic [ADDR_BITS-1:0] fb_addr,
  input  logic [DATA_BITS-1:0] fb_rd_data,
  output logic [3:0]           vga_red,
  output logic [3:0]           vga_green,
  output logic [3:0]           vga_blue,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 frame_start,
  output logic                 addr_overrun
);

  localparam int L = READ_LATENCY + 2;
  // Delay-line depth; the output register supplies the final stage.
  localparam int D = L - 1;
  localparam logic [ADDR_BITS:0] PIXELS = (ADDR_BITS + 1)'(H_VISIBLE * V_VISIBLE);

  logic [ADDR_BITS-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_BITS-1:0] fb_addr_q, fb_addr_d;
  logic [ADDR_BITS-1:0] addr_next;
  logic                 fb_rd_en_q, fb_rd_en_d;
  logic                 overrun_q, overrun_d;
  logic                 first;
  logic [D-1:0]         vis_dly_q, vis_dly_d;
  logic [D-1:0]         hs_dly_q, hs_dly_d;
  logic [D-1:0]         vs_dly_q, vs_dly_d;
  logic [D-1:0]         first_dly_q, first_dly_d;
  logic [11:0]          rgb_q, rgb_d;
  logic                 hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic                 unused_data_bits;

  // Only the low 12 bits carry 4:4:4 colour.
  assign unused_data_bits = ^fb_rd_data;

  always_comb begin
    first      = visible && (column == 10'd0) && (row == 10'd0);
    // Pixel (0,0) realigns the counter so a lost sync recovers every frame.
    addr_next  = ((column == 10'd0) && (row == 10'd0)) ? '0 : addr_cnt_q;
    addr_cnt_d = addr_cnt_q;
    fb_addr_d  = fb_addr_q;
    fb_rd_en_d = 1'b0;
    overrun_d  = overrun_q;
    if (visible) begin
      fb_addr_d  = addr_next;
      fb_rd_en_d = 1'b1;
      addr_cnt_d = addr_next + 1'b1;
      if ({1'b0, addr_next} >= PIXELS) begin
        overrun_d = 1'b1;
      end
    end

    vis_dly_d   = {vis_dly_q[D-2:0], visible};
    hs_dly_d    = {hs_dly_q[D-2:0], hsync};
    vs_dly_d    = {vs_dly_q[D-2:0], vsync};
    first_dly_d = {first_dly_q[D-2:0], first};

    rgb_d = vis_dly_q[D-1] ? fb_rd_data[11:0] : 12'h000;
    hs_d  = hs_dly_q[D-1];
    vs_d  = vs_dly_q[D-1];
    fs_d  = first_dly_q[D-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_cnt_q  <= '0;
      fb_addr_q   <= '0;
      fb_rd_en_q  <= 1'b0;
      overrun_q   <= 1'b0;
      vis_dly_q   <= '0;
      hs_dly_q    <= '1;
      vs_dly_q    <= '1;
      first_dly_q <= '0;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      addr_cnt_q  <= addr_cnt_d;
      fb_addr_q   <= fb_addr_d;
      fb_rd_en_q  <= fb_rd_en_d;
      overrun_q   <= overrun_d;
      vis_dly_q   <= vis_dly_d;
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
      first_dly_q <= first_dly_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
    end
  end

  assign fb_addr      = fb_addr_q;
  assign fb_rd_en     = fb_rd_en_q;
  assign vga_red      = rgb_q[11:8];
  assign vga_green    = rgb_q[7:4];
  assign vga_blue     = rgb_q[3:0];
  assign vga_hsync    = hs_q;
  assign vga_vsync    = vs_q;
  assign frame_start  = fs_q;
  assign addr_overrun = overrun_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: a reduced-height 800-wide VGA timing source drives a
// READ_LATENCY=2 and a READ_LATENCY=1 instance, each fed by its own SRAM model.
module tb_vga_fb_scanout;

  localparam int H_VIS   = 640;
  localparam int V_VIS   = 8;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 12;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int PIX     = H_VIS * V_VIS;
  localparam int L0      = 4;
  localparam int L1      = 3;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        visible = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [9:0]  column = '0, row = '0;

  logic        rd_en0, rd_en1;
  logic [19:0] addr0, addr1;
  logic [15:0] rd_data0, rd_data1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, fs0, ovr0, hs1, vs1, fs1, ovr1;

  logic [19:0] sram0_pipe [2];
  logic [19:0] sram1_pipe;

  vga_fb_scanout #(.H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS), .ADDR_BITS(20),
                   .DATA_BITS(16), .READ_LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .visible(visible), .hsync(hsync), .vsync(vsync),
    .column(column), .row(row), .fb_rd_en(rd_en0), .fb_addr(addr0),
    .fb_rd_data(rd_data0), .vga_red(r0), .vga_green(g0), .vga_blue(b0),
    .vga_hsync(hs0), .vga_vsync(vs0), .frame_start(fs0), .addr_overrun(ovr0));

  vga_fb_scanout #(.H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS), .ADDR_BITS(20),
                   .DATA_BITS(16), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .visible(visible), .hsync(hsync), .vsync(vsync),
    .column(column), .row(row), .fb_rd_en(rd_en1), .fb_addr(addr1),
    .fb_rd_data(rd_data1), .vga_red(r1), .vga_green(g1), .vga_blue(b1),
    .vga_hsync(hs1), .vga_vsync(vs1), .frame_start(fs1), .addr_overrun(ovr1));

  always #5 clk = ~clk;

  // SRAM models: data = address[11:0], with junk in the ignored top nibble.
  always @(posedge clk) begin
    sram0_pipe[0] <= addr0;
    sram0_pipe[1] <= sram0_pipe[0];
    sram1_pipe    <= addr1;
  end
  assign rd_data0 = {4'hA, sram0_pipe[1][11:0]};
  assign rd_data1 = {4'h5, sram1_pipe[11:0]};

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  exp_t blank_e  = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  int gcol = 0, grow = 0;
  bit skip00 = 1'b0;
  int cnt = 0, exp_addr = 0, cyc = 0, last_fs = -1, fs_cnt = 0;
  bit ovr = 1'b0, synced = 1'b0, exp_ren = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rst_in);
    exp_t e;
    exp_t e1;
    int   a;
    bit   first;
    @(negedge clk);
    reset   = rst_in;
    visible = (gcol < H_VIS) && (grow < V_VIS);
    hsync   = !(gcol >= 656 && gcol < 752);
    vsync   = !(grow >= 9 && grow < 11);
    column  = 10'(gcol);
    row     = 10'(grow);
    if (rst_in) begin
      cnt = 0; exp_addr = 0; ovr = 1'b0; synced = 1'b0; exp_ren = 1'b0; last_fs = -1;
      q.delete();
      repeat (L0 - 1) q.push_back(blank_e);
    end else begin
      first = visible && gcol == 0 && grow == 0;
      a = (gcol == 0 && grow == 0) ? 0 : cnt;
      if (first) synced = 1'b1;
      exp_ren = visible;
      if (visible) begin
        exp_addr = synced ? (grow * H_VIS + gcol) : a;
        cnt = (a + 1) % (1 << 20);
        if (a >= PIX) ovr = 1'b1;
      end
      e.rgb = visible ? 12'(exp_addr) : 12'h000;
      e.hs  = hsync;
      e.vs  = vsync;
      e.fs  = first;
      q.push_back(e);
      gcol++;
      if (gcol == H_TOTAL) begin
        gcol = 0;
        grow++;
        if (grow == V_TOTAL) grow = skip00 ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_in) begin
      check_val("rst_rgb", {r0, g0, b0, r1, g1, b1}, 0);
      check_val("rst_sync", {hs0, vs0, hs1, vs1}, 4'hF);
      check_val("rst_flags", {fs0, ovr0, fs1, ovr1, rd_en0, rd_en1}, 0);
      check_val("rst_addr", {12'h0, addr0}, 0);
    end else begin
      check_val("rd_en", {rd_en0, rd_en1}, {exp_ren, exp_ren});
      check_val("fb_addr", {12'h0, addr0}, exp_addr);
      check_val("fb_addr_rl1", {12'h0, addr1}, exp_addr);
      check_val("overrun", {ovr0, ovr1}, {ovr, ovr});
      if (q.size() >= L1) begin
        e1 = q[q.size() - L1];
        check_val("rgb_rl1", {r1, g1, b1}, e1.rgb);
        check_val("sync_rl1", {hs1, vs1, fs1}, {e1.hs, e1.vs, e1.fs});
      end
      if (q.size() >= L0) begin
        e = q.pop_front();
        check_val("rgb", {r0, g0, b0}, e.rgb);
        check_val("hsync", hs0, e.hs);
        check_val("vsync", vs0, e.vs);
        check_val("frame_start", fs0, e.fs);
      end
      if (fs0) begin
        fs_cnt++;
        if (last_fs >= 0) check_val("fs_period", cyc - last_fs, FRAME);
        last_fs = cyc;
      end
    end
  endtask

  initial begin
    // Reset held with the timing source parked at (0,0), then two full frames.
    repeat (5) step(1'b1);
    fs_cnt = 0;
    repeat (2 * FRAME) step(1'b0);
    check_val("fs_count", fs_cnt, 2);

    // Reset mid-line in row 2; the block free-runs until the next (0,0).
    repeat (2 * H_TOTAL + 300) step(1'b0);
    repeat (3) step(1'b1);
    repeat (FRAME + 100) step(1'b0);

    // A source that restarts at row 1 never shows (0,0) and must overrun.
    gcol = 0; grow = 1; skip00 = 1'b1;
    repeat (2) step(1'b1);
    repeat (10000) step(1'b0);
    check_val("overrun_set", {ovr0, ovr1}, 2'b11);

    skip00 = 1'b0; gcol = 0; grow = 0;
    repeat (2) step(1'b1);
    repeat (50) step(1'b0);
    check_val("overrun_clear", {ovr0, ovr1}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
